// File: rtl/dmi_arbiter_pkg.sv
// Shared DMI field widths, op/response codes and arbiter state encodings.
package dmi_arb_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_SUCCESS = 2'd0,
    DMI_FAILED  = 2'd2,
    DMI_BUSY    = 2'd3
  } dmi_resp_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dmi_arbiter_if.sv
// Requester-side and debug-module-side DMI handshakes of the arbiter.
// slave = the arbiter, master = transports plus debug module.
interface dmi_arbiter_if #(parameter int N_REQ = 2);
  import dmi_arb_pkg::*;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DMI_ADDR_W-1:0] req_addr;
  logic [N_REQ*2-1:0]          req_op;
  logic [N_REQ*DMI_DATA_W-1:0] req_data;
  logic [N_REQ-1:0]            resp_valid;
  logic [N_REQ-1:0]            resp_ready;
  logic [1:0]                  resp_resp;
  logic [DMI_DATA_W-1:0]       resp_data;

  logic                  dmi_req_valid;
  logic                  dmi_req_ready;
  logic [DMI_ADDR_W-1:0] dmi_req_addr;
  logic [1:0]            dmi_req_op;
  logic [DMI_DATA_W-1:0] dmi_req_data;
  logic                  dmi_resp_valid;
  logic                  dmi_resp_ready;
  logic [1:0]            dmi_resp_resp;
  logic [DMI_DATA_W-1:0] dmi_resp_data;

  modport slave (
    input  req_valid, req_addr, req_op, req_data, resp_ready,
           dmi_req_ready, dmi_resp_valid, dmi_resp_resp, dmi_resp_data,
    output req_ready, resp_valid, resp_resp, resp_data,
           dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready
  );

  modport master (
    output req_valid, req_addr, req_op, req_data, resp_ready,
           dmi_req_ready, dmi_resp_valid, dmi_resp_resp, dmi_resp_data,
    input  req_ready, resp_valid, resp_resp, resp_data,
           dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready
  );

endinterface

// File: rtl/dmi_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module dmi_rr_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(N_REQ);

  int   j;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin share of one DMI port between N_REQ transports, one transaction in flight.
// Optional response timeout under DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  dmi_arbiter_if.slave             bus,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [1:0] S_IDLE  = ARB_IDLE;
  localparam logic [1:0] S_ISSUE = ARB_ISSUE;
  localparam logic [1:0] S_WAIT  = ARB_WAIT;
  localparam logic [1:0] S_RESP  = ARB_RESP;

  logic [1:0]       state;
  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic [N_REQ-1:0] owner_oh;
  logic             req_hs;
  logic             timed_out;

  dmi_rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = (state == S_IDLE) ? gnt : '0;
  assign req_hs        = (state == S_IDLE) && (|bus.req_valid);
  assign owner_oh      = N_REQ'(1) << owner;

`ifdef DMI_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 wait_cnt <= '0;
    else if (state == S_ISSUE) wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 32'd1;
  end

  assign timed_out = (wait_cnt == 32'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      rr_ptr             <= '0;
      owner              <= '0;
      busy               <= 1'b0;
      bus.dmi_req_valid  <= 1'b0;
      bus.dmi_req_addr   <= '0;
      bus.dmi_req_op     <= '0;
      bus.dmi_req_data   <= '0;
      bus.dmi_resp_ready <= 1'b0;
      bus.resp_valid     <= '0;
      bus.resp_resp      <= '0;
      bus.resp_data      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
`ifdef DMI_ARB_TIMEOUT_EN
          // Late responses to a timed-out transaction are drained while idle.
          bus.dmi_resp_ready <= !req_hs;
`endif
          if (req_hs) begin
            bus.dmi_req_addr  <= bus.req_addr[int'(gnt_idx)*DMI_ADDR_W +: DMI_ADDR_W];
            bus.dmi_req_op    <= bus.req_op[int'(gnt_idx)*2 +: 2];
            bus.dmi_req_data  <= bus.req_data[int'(gnt_idx)*DMI_DATA_W +: DMI_DATA_W];
            bus.dmi_req_valid <= 1'b1;
            owner             <= gnt_idx;
            rr_ptr            <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            busy              <= 1'b1;
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.dmi_req_ready) begin
            bus.dmi_req_valid  <= 1'b0;
            bus.dmi_resp_ready <= 1'b1;
            state              <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.dmi_resp_valid || timed_out) begin
            bus.resp_resp      <= bus.dmi_resp_valid ? bus.dmi_resp_resp : DMI_FAILED;
            bus.resp_data      <= bus.dmi_resp_valid ? bus.dmi_resp_data : '0;
            bus.resp_valid     <= owner_oh;
            bus.dmi_resp_ready <= 1'b0;
            state              <= S_RESP;
          end
        end
        default: begin
          if (|(bus.resp_ready & owner_oh)) begin
            bus.resp_valid <= '0;
            busy           <= 1'b0;
            state          <= S_IDLE;
`ifdef DMI_ARB_TIMEOUT_EN
            bus.dmi_resp_ready <= 1'b1;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed-vector bench for dmi_arbiter, two requesters; timeout case built with DMI_ARB_TIMEOUT_EN.
module tb_dmi_arbiter;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] owner;
  logic       busy;
  int         vec  = 0;
  int         miss = 0;

  int         exp_g [4] = '{0, 1, 0, 1};
  logic [6:0] caddr [2] = '{7'h20, 7'h31};

  dmi_arbiter_if #(.N_REQ(N)) bus ();

  dmi_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid      = '0;
    bus.req_addr       = '0;
    bus.req_op         = '0;
    bus.req_data       = '0;
    bus.resp_ready     = '0;
    bus.dmi_req_ready  = 1'b0;
    bus.dmi_resp_valid = 1'b0;
    bus.dmi_resp_resp  = '0;
    bus.dmi_resp_data  = '0;
  endtask

  // One complete transaction from requester r, entered during the low clock phase with the DUT idle.
  task automatic do_txn(input string tag, input int r, input logic [6:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic [1:0] rc, input logic [31:0] rd, input int dly);
    bus.req_valid         = 2'b01 << r;
    bus.req_addr[r*7 +: 7]  = a;
    bus.req_op[r*2 +: 2]    = op;
    bus.req_data[r*32 +: 32] = wd;
    #1 chk({tag, "_req_ready"}, bus.req_ready, 2'b01 << r);
    @(negedge clk);
    bus.req_valid = '0;
    chk({tag, "_dmi_vld"}, bus.dmi_req_valid, 1);
    chk({tag, "_dmi_fields"}, {bus.dmi_req_addr, bus.dmi_req_op, bus.dmi_req_data}, {a, op, wd});
    chk({tag, "_owner"}, owner, r);
    bus.dmi_req_ready = 1'b1;
    @(negedge clk);
    bus.dmi_req_ready = 1'b0;
    chk({tag, "_wait"}, {bus.dmi_req_valid, bus.dmi_resp_ready}, 2'b01);
    repeat (dly) @(negedge clk);
    chk({tag, "_no_early_rv"}, bus.resp_valid, 0);
    bus.dmi_resp_valid = 1'b1;
    bus.dmi_resp_resp  = rc;
    bus.dmi_resp_data  = rd;
    @(negedge clk);
    bus.dmi_resp_valid = 1'b0;
    chk({tag, "_resp_valid"}, bus.resp_valid, 2'b01 << r);
    chk({tag, "_resp"}, {bus.resp_resp, bus.resp_data}, {rc, rd});
    bus.resp_ready = 2'b01 << r;
    @(negedge clk);
    bus.resp_ready = '0;
    chk({tag, "_done"}, {bus.resp_valid, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng;
    int nr;
    int last;
    int c;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy_owner", {busy, owner}, 0);
    chk("rst_valids", {bus.dmi_req_valid, bus.dmi_resp_ready, bus.resp_valid, bus.req_ready}, 0);
    chk("rst_fields", {bus.dmi_req_addr, bus.dmi_req_op, bus.dmi_req_data, bus.resp_resp, bus.resp_data}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_txn("rd", 0, 7'h11, 2'd1, 32'h0, 2'd0, 32'hDEADBEEF, 2);
    do_txn("nop", 1, 7'h22, 2'd0, 32'h0000_00AA, 2'd2, 32'h0BAD_F00D, 0);

    // Contention: both requesters always valid, downstream always ready/valid.
    bus.req_valid      = 2'b11;
    bus.req_addr       = {7'h31, 7'h20};
    bus.req_op         = {2'd2, 2'd1};
    bus.dmi_req_ready  = 1'b1;
    bus.dmi_resp_valid = 1'b1;
    bus.dmi_resp_data  = 32'h5A5A_0000;
    bus.resp_ready     = 2'b11;
    ng = 0; nr = 0; last = 0;
    for (int i = 0; i < 40 && nr < 4; i++) begin
      #1;
      if (bus.req_ready != 0 && ng < 4) begin
        chk("cont_grant", bus.req_ready, 2'b01 << exp_g[ng]);
        ng++;
      end
      if (bus.dmi_req_valid && ng > 0) chk("cont_addr", bus.dmi_req_addr, caddr[exp_g[ng-1]]);
      if (bus.resp_valid != 0) begin
        chk("cont_owner", owner, exp_g[nr]);
        chk("cont_resp_valid", bus.resp_valid, 2'b01 << exp_g[nr]);
        if (nr > 0) chk("cont_period", i - last, 4);
        last = i;
        nr++;
        if (nr == 4) bus.req_valid = '0;
      end
      @(negedge clk);
    end
    chk("cont_count", nr, 4);
    idle_inputs();
    @(negedge clk);

    // Backpressure on both sides, with requester 0 queuing behind requester 1.
    bus.req_valid = 2'b10;
    bus.req_addr  = {7'h05, 7'h44};
    bus.req_op    = {2'd2, 2'd1};
    bus.req_data  = {32'h1234_5678, 32'h0};
    #1 chk("bp_grant", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_vld", bus.dmi_req_valid, 1);
      chk("bp_hold_fields", {bus.dmi_req_addr, bus.dmi_req_op, bus.dmi_req_data}, {7'h05, 2'd2, 32'h1234_5678});
      chk("bp_no_grant", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.dmi_req_ready = 1'b1;
    @(negedge clk);
    bus.dmi_req_ready  = 1'b0;
    chk("bp_wait", bus.dmi_resp_ready, 1);
    bus.dmi_resp_valid = 1'b1;
    bus.dmi_resp_resp  = 2'd3;
    bus.dmi_resp_data  = 32'hCAFE_0001;
    @(negedge clk);
    bus.dmi_resp_valid = 1'b0;
    bus.resp_ready     = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_resp_valid", bus.resp_valid, 2'b10);
      chk("bp_resp_hold", {bus.resp_resp, bus.resp_data}, {2'd3, 32'hCAFE_0001});
      chk("bp_resp_no_grant", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.resp_ready = 2'b10;
    @(negedge clk);
    bus.resp_ready = '0;
    #1;
    chk("bp_single_resp", {bus.resp_valid, busy}, 0);
    chk("bp_next_grant", bus.req_ready, 2'b01);

    // Reset while the queued request sits in WAIT.
    @(negedge clk);
    bus.req_valid = '0;
    chk("rst_mid_addr", bus.dmi_req_addr, 7'h44);
    bus.dmi_req_ready = 1'b1;
    @(negedge clk);
    bus.dmi_req_ready = 1'b0;
    chk("rst_mid_wait", {busy, bus.dmi_resp_ready}, 2'b11);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mid_state", {busy, owner, bus.dmi_req_valid, bus.dmi_resp_ready, bus.resp_valid}, 0);
    reset = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1 chk("rst_mid_rr_ptr", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    do_txn("post_rst", 0, 7'h3C, 2'd2, 32'hA5A5_5A5A, 2'd0, 32'h0, 1);

`ifdef DMI_ARB_TIMEOUT_EN
    bus.req_valid = 2'b01;
    bus.req_addr  = {7'h00, 7'h07};
    bus.req_op    = {2'd0, 2'd1};
    @(negedge clk);
    bus.req_valid     = '0;
    bus.dmi_req_ready = 1'b1;
    @(negedge clk);
    bus.dmi_req_ready = 1'b0;
    c = 0;
    while (bus.resp_valid == 0 && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk("to_cycles", c, 16);
    chk("to_resp", {bus.resp_valid, bus.resp_resp, bus.resp_data}, {2'b01, 2'd2, 32'h0});
    bus.resp_ready = 2'b01;
    @(negedge clk);
    bus.resp_ready = '0;
    chk("to_idle_ready", bus.dmi_resp_ready, 1);
    bus.dmi_resp_valid = 1'b1;
    bus.dmi_resp_data  = 32'h0000_1234;
    @(negedge clk);
    bus.dmi_resp_valid = 1'b0;
    chk("to_late_dropped", {bus.resp_valid, busy}, 0);
    @(negedge clk);
    chk("to_late_still_dropped", bus.resp_valid, 0);
`else
    c = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares one Debug Module Interface (DMI) port between N_REQ debug transport requesters, e.g. the simulation DTM and a JTAG DTM. Sits between the transports and the debug module. Allows one outstanding transaction at a time, picks requesters round-robin, and routes each response back only to the requester that issued it. All downstream outputs are registered.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..8)
- TIMEOUT, 1024, cycles to wait for a response before failing the transaction (used only with DMI_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester request ready
- req_addr  in  N_REQ*7  packed request addresses; requester i uses bits [7i+6:7i]
- req_op  in  N_REQ*2  packed ops: 0 nop, 1 read, 2 write
- req_data  in  N_REQ*32  packed write data
- resp_valid  out  N_REQ  per-requester response valid
- resp_ready  in  N_REQ  per-requester response ready
- resp_resp  out  2  response code, shared by all requesters: 0 success, 2 failed, 3 busy
- resp_data  out  32  response data, shared by all requesters
- dmi_req_valid / dmi_req_ready  out / in  1  downstream request handshake
- dmi_req_addr / dmi_req_op / dmi_req_data  out  7 / 2 / 32  downstream request fields
- dmi_resp_valid / dmi_resp_ready  in / out  1  downstream response handshake
- dmi_resp_resp / dmi_resp_data  in  2 / 32  downstream response fields
- owner  out  clog2(N_REQ)  index of the requester that owns the current transaction
- busy  out  1  high whenever the state is not IDLE

## Operation
State machine with four states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Grant = first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[grant] = 1; req_ready is 0 for every other requester, and 0 for all requesters in every other state.
  - On handshake: latch addr/op/data, set owner = grant, set rr_ptr = grant+1 mod N_REQ, go to ISSUE.
- ISSUE
  - dmi_req_valid = 1 with the latched fields.
  - On dmi_req_ready: go to WAIT.
- WAIT
  - dmi_resp_ready = 1.
  - On dmi_resp_valid: latch resp/data, go to RESP.
- RESP
  - resp_valid[owner] = 1; every other resp_valid bit is 0.
  - On resp_ready[owner]: go to IDLE. resp_ready from non-owners is ignored.
- Ops are forwarded unchanged, nop included; every accepted request produces exactly one response.
- Outputs out of reset: all valid/ready outputs 0, dmi_req fields 0, resp_resp/resp_data 0, owner 0, busy 0, rr_ptr 0, state IDLE.
- Reset asserted mid-transaction: the transaction is abandoned immediately and no response is delivered.
- A new request is never granted in the same cycle a response completes. RESP→IDLE takes one cycle; the grant happens in IDLE.

## Timing
- Requester handshake in cycle t → dmi_req_valid high from cycle t+1.
- dmi_req handshake in cycle t → dmi_resp_ready high from t+1.
- dmi_resp handshake in cycle t → resp_valid[owner] high from t+1.
- Back-to-back best case: 4 cycles per transaction (IDLE, ISSUE, WAIT, RESP), each phase accepted in its first cycle.
- req_ready depends combinationally on req_valid and rr_ptr. No other output depends combinationally on an input.
- dmi_req fields and resp fields stay stable while their valid is high.

## Configuration
- DMI_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT-1 with no dmi_resp_valid, the block goes to RESP with resp_resp=2 (failed) and resp_data=0.
  - dmi_resp_ready is also 1 in IDLE, so a late response is accepted and discarded.
- DMI_ARB_TIMEOUT_EN undefined: WAIT is unbounded and dmi_resp_ready is 0 in IDLE.

## Structure
- Package dmi_arb_pkg holds:
  - DMI_ADDR_W=7, DMI_DATA_W=32
  - dmi_op_e (NOP/READ/WRITE)
  - dmi_resp_e (SUCCESS=0, FAILED=2, BUSY=3)
  - arb_state_e (IDLE/ISSUE/WAIT/RESP)
- Sub-module dmi_rr_picker: combinational round-robin pick. Inputs: N_REQ request vector and pointer. Outputs: one-hot grant and grant index.

## Test plan
- Single read: requester 0 sends op=1, addr=0x11; downstream returns resp=0, data=0xDEADBEEF after 3 cycles → resp_valid[0] only, data 0xDEADBEEF, resp_valid[1] stays 0.
- Contention: both requesters hold valid continuously for 4 transactions → grants go 0,1,0,1 and owner matches each response.
- Backpressure: dmi_req_ready low for 5 cycles, then resp_ready[1] low for 3 cycles → fields stay stable throughout, no new grant until completion, exactly one response.
- Reset during WAIT: assert reset for 2 cycles → busy=0, all valids 0, rr_ptr=0; the next request is issued normally.
- Nop pass-through: requester 1 sends op=0 → dmi_req_op=0 forwarded, response returned to requester 1 with the downstream resp code.
- With DMI_ARB_TIMEOUT_EN and TIMEOUT=16, downstream never responds → resp_valid[owner] at WAIT entry+16 with resp=2, data=0; a response arriving later in IDLE is consumed and not forwarded.
